// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the FIFO family
// Provides clog2 for pointer sizing and the default data width / depth.
package fifo_pkg;
  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: DEPTH x DATA_W register array, sync write port, registered read port
// Ports: clk, reset (async, clears dout only); wr_en/wr_addr/din write port;
// rd_en/rd_addr read port; dout holds its value until the next enabled read.
module fifo_mem_2p import fifo_pkg::*; #(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q, dout_d;
  // Storage is deliberately not reset; the top only enables reads of written entries.
  always_ff @(posedge clk) if (wr_en) mem_q[wr_addr] <= din;
  always_comb dout_d = rd_en ? mem_q[rd_addr] : dout_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) dout_q <= '0;
    else dout_q <= dout_d;
  assign dout = dout_q;
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock circular-buffer FIFO
// Ports: clk, reset (async active-high); wr_en/din write side; rd_en/dout read
// side (1-cycle registered read); full/empty/almost_full/almost_empty/count
// status decoded from the registered count; overflow/underflow one-cycle pulses.
module fifo_sync_param import fifo_pkg::*; #(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2,
  localparam int AW       = clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic          rd_ok, wr_ok;
  assign full         = count_q == CW'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CW'(AFULL_TH);
  assign almost_empty = count_q <= CW'(AEMPTY_TH);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign rd_ok = rd_en && !empty;
  // A read in the same cycle frees the slot a write into a full FIFO needs.
  assign wr_ok = wr_en && (!full || rd_en);
  always_comb begin
    wr_ptr_d    = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = (wr_ok && !rd_ok) ? count_q + CW'(1) :
                  (rd_ok && !wr_ok) ? count_q - CW'(1) : count_q;
    overflow_d  = wr_en && !wr_ok;
    underflow_d = rd_en && !rd_ok;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  fifo_mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .din     (din),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr_q),
    .dout    (dout)
  );
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed self-checking bench for default and small/wide FIFO configurations
module tb_fifo_sync_param;
  logic clk = 1'b0, reset = 1'b1;
  logic wr_a = 1'b0, rd_a = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
  logic [7:0]  din_a = '0, dout_a;
  logic [31:0] din_b = '0, dout_b;
  logic full_a, empty_a, af_a, ae_a, ov_a, un_a;
  logic full_b, empty_b, af_b, ae_b, ov_b, un_b;
  logic [4:0] count_a;
  logic [2:0] count_b;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  fifo_sync_param dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_a), .din(din_a), .rd_en(rd_a), .dout(dout_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .count(count_a), .overflow(ov_a), .underflow(un_a)
  );
  fifo_sync_param #(.DATA_W(32), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_b), .din(din_b), .rd_en(rd_b), .dout(dout_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .count(count_b), .overflow(ov_b), .underflow(un_b)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input bit b, input bit w, input bit r, input logic [31:0] d);
    if (b) begin wr_b = w; rd_b = r; din_b = d; end
    else begin wr_a = w; rd_a = r; din_a = d[7:0]; end
    @(posedge clk); #1;
    wr_a = 0; rd_a = 0; wr_b = 0; rd_b = 0;
  endtask
  initial begin
    #2;
    chk("rst_count", count_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_aempty", ae_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_afull", af_a, 0);
    chk("rst_dout", dout_a, 0);
    chk("rst_ovf", ov_a, 0);
    chk("rst_unf", un_a, 0);
    chk("rst_b_empty", empty_b, 1);
    #10 reset = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, i);
      chk($sformatf("fill_count%0d", i), count_a, i + 1);
      chk($sformatf("fill_afull%0d", i), af_a, (i + 1) >= 14);
      chk($sformatf("fill_full%0d", i), full_a, (i + 1) == 16);
      chk($sformatf("fill_aempty%0d", i), ae_a, (i + 1) <= 2);
      chk($sformatf("fill_ovf%0d", i), ov_a, 0);
    end
    cyc(0, 1, 0, 8'hEE);
    chk("ovf_pulse", ov_a, 1);
    chk("ovf_count", count_a, 16);
    cyc(0, 0, 0, 0);
    chk("ovf_clear", ov_a, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      chk($sformatf("drain_dout%0d", i), dout_a, i);
      chk($sformatf("drain_count%0d", i), count_a, 15 - i);
      chk($sformatf("drain_empty%0d", i), empty_a, i == 15);
    end
    cyc(0, 0, 1, 0);
    chk("unf_pulse", un_a, 1);
    chk("unf_dout_hold", dout_a, 8'h0F);
    cyc(0, 0, 0, 0);
    chk("unf_clear", un_a, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'h10 + i);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 0);
      chk($sformatf("pre_wrap_dout%0d", i), dout_a, 8'h10 + i);
    end
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 8'hA0 + i);
    chk("wrap_count", count_a, 12);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 0);
      chk($sformatf("wrap_dout%0d", i), dout_a, 8'hA0 + i);
    end
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 8'h60 + i);
    chk("sim_full_pre", full_a, 1);
    cyc(0, 1, 1, 8'h55);
    chk("sim_full_count", count_a, 16);
    chk("sim_full_dout", dout_a, 8'h60);
    chk("sim_full_ovf", ov_a, 0);
    chk("sim_full_full", full_a, 1);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      chk($sformatf("sim_drain%0d", i), dout_a, 8'h60 + i);
    end
    cyc(0, 0, 1, 0);
    chk("sim_drain_last", dout_a, 8'h55);
    chk("sim_drain_empty", empty_a, 1);
    cyc(0, 1, 1, 8'h77);
    chk("sim_empty_count", count_a, 1);
    chk("sim_empty_unf", un_a, 1);
    chk("sim_empty_dout", dout_a, 8'h55);
    cyc(0, 0, 1, 0);
    chk("sim_empty_read", dout_a, 8'h77);
    chk("sim_empty_count0", count_a, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 8'hC0 + i);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 8'hC7);
    chk("mid_count7", count_a, 7);
    chk("mid_dout", dout_a, 8'hC0);
    #2 reset = 1;
    #1;
    chk("async_count", count_a, 0);
    chk("async_empty", empty_a, 1);
    chk("async_aempty", ae_a, 1);
    chk("async_dout", dout_a, 0);
    chk("async_full", full_a, 0);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    cyc(0, 1, 0, 8'h3C);
    chk("post_rst_count", count_a, 1);
    cyc(0, 0, 1, 0);
    chk("post_rst_dout", dout_a, 8'h3C);
    chk("post_rst_empty", empty_a, 1);
    chk("b_idle_empty", empty_b, 1);
    chk("b_idle_aempty", ae_b, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 32'hDEAD_0000 + i);
      chk($sformatf("b_fill_count%0d", i), count_b, i + 1);
      chk($sformatf("b_fill_afull%0d", i), af_b, (i + 1) >= 3);
      chk($sformatf("b_fill_aempty%0d", i), ae_b, (i + 1) <= 1);
      chk($sformatf("b_fill_full%0d", i), full_b, (i + 1) == 4);
    end
    cyc(1, 1, 0, 32'hFFFF_FFFF);
    chk("b_ovf", ov_b, 1);
    chk("b_ovf_count", count_b, 4);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 0);
      chk($sformatf("b_drain_dout%0d", i), dout_b, 32'hDEAD_0000 + i);
      chk($sformatf("b_drain_afull%0d", i), af_b, (3 - i) >= 3);
      chk($sformatf("b_drain_aempty%0d", i), ae_b, (3 - i) <= 1);
      chk($sformatf("b_drain_empty%0d", i), empty_b, i == 3);
    end
    cyc(1, 0, 1, 0);
    chk("b_unf", un_b, 1);
    chk("b_unf_dout", dout_b, 32'hDEAD_0003);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
